// File: rtl/drac_pkg.sv
// Shared core types for the CSR path: command encoding, address width, sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package drac_pkg;

  localparam int CSR_CMD_SIZE  = 4;
  localparam int CSR_ADDR_SIZE = 12;

  typedef logic [63:0] bus64_t;

  typedef enum logic [CSR_CMD_SIZE-1:0] {
    CSR_CMD_NOPE     = 4'd0,
    CSR_CMD_WRITE    = 4'd1,
    CSR_CMD_SET      = 4'd2,
    CSR_CMD_CLEAR    = 4'd3,
    CSR_CMD_SYS      = 4'd4,
    CSR_CMD_READ     = 4'd5,
    CSR_CMD_RW       = 4'd6,
    CSR_CMD_VSETVL   = 4'd7,
    CSR_CMD_VSETVLI  = 4'd8,
    CSR_CMD_VSETIVLI = 4'd9,
    CSR_CMD_VLEFF    = 4'd10
  } csr_cmd_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } csr_seq_state_t;

  // Everything except a pure read may change architectural state the
  // younger instructions already depend on, so it forces a pipeline flush.
  function automatic logic csr_has_side_effect(input csr_cmd_t cmd);
    return (cmd != CSR_CMD_READ) && (cmd != CSR_CMD_NOPE);
  endfunction

endpackage

// File: rtl/csr_req_sequencer.sv
// Serialises one commit CSR request into the CSR file; one request in flight, bounded wait.
// Latency: read completes 3 cycles after req_i, side-effect commands 4 (ready=1, response next cycle).
// Backpressure: request fields held stable until csr_req_ready_i; commit stalled while busy.
module csr_req_sequencer
  import drac_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     req_i,
  input  logic [CSR_CMD_SIZE-1:0]  cmd_i,
  input  logic [CSR_ADDR_SIZE-1:0] addr_i,
  input  logic [63:0]              wdata_i,
  input  logic                     kill_i,
  output logic                     csr_req_valid_o,
  output logic [CSR_CMD_SIZE-1:0]  csr_req_cmd_o,
  output logic [CSR_ADDR_SIZE-1:0] csr_req_addr_o,
  output logic [63:0]              csr_req_data_o,
  input  logic                     csr_req_ready_i,
  input  logic                     csr_resp_valid_i,
  input  logic [63:0]              csr_resp_rdata_i,
  input  logic                     csr_resp_xcpt_i,
  output logic                     stall_commit_o,
  output logic                     resp_valid_o,
  output logic [63:0]              resp_rdata_o,
  output logic                     resp_xcpt_o,
  output logic                     timeout_o,
  output logic                     flush_o,
  output logic                     busy_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  csr_seq_state_t           state_q, state_d;
  csr_cmd_t                 cmd_q, cmd_d;
  logic [CSR_ADDR_SIZE-1:0] addr_q, addr_d;
  bus64_t                   wdata_q, wdata_d;
  bus64_t                   rdata_q, rdata_d;
  logic                     xcpt_q, xcpt_d;
  logic                     tout_q, tout_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic accept;
  logic timeout_hit;

  // A NOPE command is not a real access: it neither starts a sequence nor stalls commit.
  assign accept      = req_i && !kill_i && (csr_cmd_t'(cmd_i) != CSR_CMD_NOPE);
  assign timeout_hit = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: kill only matters before the CSR file accepts; a same-cycle response beats timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = REQ;
      end
      REQ: begin
        if (kill_i)               state_d = IDLE;
        else if (csr_req_ready_i) state_d = WAIT;
      end
      WAIT: begin
        if (csr_resp_valid_i) begin
          if (csr_resp_xcpt_i || !csr_has_side_effect(cmd_q)) state_d = DONE;
          else                                                state_d = FLUSH;
        end else if (timeout_hit) begin
          state_d = DONE;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: request latches load only on entry to REQ, response captured in WAIT
  always_comb begin
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    xcpt_d  = xcpt_q;
    tout_d  = tout_q;
    cnt_d   = cnt_q;

    if ((state_q == IDLE) && accept) begin
      cmd_d   = csr_cmd_t'(cmd_i);
      addr_d  = addr_i;
      wdata_d = wdata_i;
      rdata_d = '0;
      xcpt_d  = 1'b0;
      tout_d  = 1'b0;
    end

    if ((state_q == REQ) && csr_req_ready_i) begin
      cnt_d = '0;
    end

    if (state_q == WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (csr_resp_valid_i) begin
        rdata_d = csr_resp_rdata_i;
        xcpt_d  = csr_resp_xcpt_i;
        tout_d  = 1'b0;
      end else if (timeout_hit) begin
        xcpt_d  = 1'b1;
        tout_d  = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cmd_q   <= CSR_CMD_NOPE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      xcpt_q  <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      xcpt_q  <= xcpt_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs: decoded from state; stall also covers the cycle a new request appears
  always_comb begin
    csr_req_valid_o = (state_q == REQ);
    csr_req_cmd_o   = cmd_q;
    csr_req_addr_o  = addr_q;
    csr_req_data_o  = wdata_q;
    busy_o          = (state_q != IDLE);
    stall_commit_o  = (state_q != IDLE) || accept;
    flush_o         = (state_q == FLUSH);
    resp_valid_o    = (state_q == DONE);
    resp_rdata_o    = rdata_q;
    resp_xcpt_o     = (state_q == DONE) && xcpt_q;
    timeout_o       = (state_q == DONE) && tout_q;
  end

endmodule
